// File: rtl/sound_reg_if.sv
// rtl/sound_reg_if.sv - SN76477 CPU register interface with tick-aligned commit,
// one-shot trigger hold and volume scaling of the generator magnitude.
module sound_reg_if #(
  parameter int          TRIG_HOLD = 4,
  parameter logic [7:0]  RESET_C   = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_48k,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [1:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic [1:0]  attack_sel,
  output logic [1:0]  decay_sel,
  output logic [1:0]  slf_sel,
  output logic        vco_pitch,
  output logic        noise_pink,
  output logic [2:0]  mixer_ctl,
  output logic [1:0]  envsel,
  output logic        vco_sel,
  output logic        vco_ext,
  output logic        inhibit,
  input  logic [13:0] magnitude,
  output logic [15:0] audio_out
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(TRIG_HOLD);

  state_t      state, state_nx;
  logic [3:0]  hold_ctr, hold_ctr_nx;
  logic [7:0]  sh_a, sh_b, com_a;
  logic [6:0]  com_b;
  logic        sh_inh, sh_vol, com_inh, com_vol;
  logic        pending, trig_req;
  logic        wr_reg;
  logic [7:0]  rd_data;

  assign wr_reg = cpu_wr && (cpu_addr != 2'd3);

  // Trigger requests are latched and acted on at the next tick, so a
  // retrigger during HOLD reloads the counter rather than stacking.
  always_comb begin
    state_nx    = state;
    hold_ctr_nx = hold_ctr;
    if (ce_48k) begin
      case (state)
        IDLE: if (trig_req) begin
          state_nx    = HOLD;
          hold_ctr_nx = HOLD_LOAD;
        end
        HOLD: begin
          if (trig_req) begin
            hold_ctr_nx = HOLD_LOAD;
          end else if (hold_ctr <= 4'd1) begin
            state_nx    = IDLE;
            hold_ctr_nx = 4'd0;
          end else begin
            hold_ctr_nx = hold_ctr - 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_ctr <= 4'd0;
    end else begin
      state    <= state_nx;
      hold_ctr <= hold_ctr_nx;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (cpu_addr)
      2'd0: rd_data = sh_a;
      2'd1: rd_data = sh_b;
      2'd2: rd_data = {5'b0, sh_vol, 1'b0, sh_inh};
      default: rd_data = {6'b0, state == HOLD, pending};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a      <= 8'h00;
      sh_b      <= 8'h00;
      sh_inh    <= RESET_C[0];
      sh_vol    <= RESET_C[2];
      com_a     <= 8'h00;
      com_b     <= 7'h00;
      com_inh   <= RESET_C[0];
      com_vol   <= RESET_C[2];
      pending   <= 1'b0;
      trig_req  <= 1'b0;
      inhibit   <= 1'b1;
      audio_out <= 16'h0000;
      cpu_dout  <= 8'h00;
    end else begin
      // Commit uses the shadow values held before this cycle; a write in
      // the same cycle lands below and waits for the next tick.
      if (ce_48k) begin
        com_a     <= sh_a;
        com_b     <= sh_b[6:0];
        com_inh   <= sh_inh;
        com_vol   <= sh_vol;
        inhibit   <= (state_nx == HOLD) | sh_inh;
        audio_out <= com_vol ? {1'b0, magnitude, 1'b0} : {magnitude, 2'b00};
        pending   <= 1'b0;
        trig_req  <= 1'b0;
      end
      if (wr_reg) begin
        pending <= 1'b1;
        case (cpu_addr)
          2'd0: sh_a <= cpu_din;
          2'd1: sh_b <= cpu_din;
          default: begin
            sh_inh <= cpu_din[0];
            sh_vol <= cpu_din[2];
            if (cpu_din[1]) trig_req <= 1'b1;
          end
        endcase
      end
      if (cpu_rd) cpu_dout <= rd_data;
    end
  end

  assign attack_sel = com_a[1:0];
  assign decay_sel  = com_a[3:2];
  assign slf_sel    = com_a[5:4];
  assign vco_pitch  = com_a[6];
  assign noise_pink = com_a[7];
  assign mixer_ctl  = com_b[2:0];
  assign envsel     = com_b[4:3];
  assign vco_sel    = com_b[5];
  assign vco_ext    = com_b[6];

endmodule

// File: tb/tb_sound_reg_if.sv
// tb/tb_sound_reg_if.sv - directed and randomized checks of sound_reg_if
// against a tick-level behavioural model.
module tb_sound_reg_if;

  localparam int TH = 4;

  logic        clk = 0;
  logic        reset = 1;
  logic        ce_48k = 0, cpu_wr = 0, cpu_rd = 0;
  logic [1:0]  cpu_addr = 0;
  logic [7:0]  cpu_din = 0;
  logic [7:0]  cpu_dout;
  logic [1:0]  attack_sel, decay_sel, slf_sel, envsel;
  logic        vco_pitch, noise_pink, vco_sel, vco_ext, inhibit;
  logic [2:0]  mixer_ctl;
  logic [13:0] magnitude = 0;
  logic [15:0] audio_out;

  int vectors = 0, miscompares = 0;

  // model state
  logic [7:0]  m_sa, m_sb, m_ca, m_cb, m_dout;
  logic        m_sinh, m_svol, m_cinh, m_cvol, m_pend, m_treq;
  int          m_hold;
  logic [15:0] m_audio;

  sound_reg_if #(.TRIG_HOLD(TH), .RESET_C(8'h01)) dut (
    .clk(clk), .reset(reset), .ce_48k(ce_48k), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .attack_sel(attack_sel), .decay_sel(decay_sel), .slf_sel(slf_sel),
    .vco_pitch(vco_pitch), .noise_pink(noise_pink), .mixer_ctl(mixer_ctl),
    .envsel(envsel), .vco_sel(vco_sel), .vco_ext(vco_ext), .inhibit(inhibit),
    .magnitude(magnitude), .audio_out(audio_out)
  );

  always #20 clk = ~clk;

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return m_sa;
      2'd1: return m_sb;
      2'd2: return {5'b0, m_svol, 1'b0, m_sinh};
      default: return {6'b0, m_hold > 0, m_pend};
    endcase
  endfunction

  function automatic logic m_inhibit();
    return (m_hold > 0) || m_cinh;
  endfunction

  task automatic model_reset();
    m_sa = 0; m_sb = 0; m_ca = 0; m_cb = 0; m_dout = 0;
    m_sinh = 1; m_svol = 0; m_cinh = 1; m_cvol = 0;
    m_pend = 0; m_treq = 0; m_hold = 0; m_audio = 0;
  endtask

  // One clock with the given strobes; the model advances from pre-edge state.
  task automatic cyc(input logic wr, input logic rd, input logic [1:0] addr,
                     input logic [7:0] din, input logic ce);
    cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_din = din; ce_48k = ce;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (rd) m_dout = m_read(addr);
      if (ce) begin
        m_audio = m_cvol ? {1'b0, magnitude, 1'b0} : {magnitude, 2'b00};
        m_ca = m_sa; m_cb = m_sb; m_cinh = m_sinh; m_cvol = m_svol;
        if (m_treq) m_hold = TH;
        else if (m_hold > 0) m_hold = m_hold - 1;
        m_pend = 0; m_treq = 0;
      end
      if (wr && addr != 2'd3) begin
        m_pend = 1;
        if (addr == 2'd0) m_sa = din;
        else if (addr == 2'd1) m_sb = din;
        else begin
          m_sinh = din[0]; m_svol = din[2];
          if (din[1]) m_treq = 1;
        end
      end
    end
    #1;
    cpu_wr = 0; cpu_rd = 0; ce_48k = 0;
  endtask

  task automatic tick();
    cyc(0, 0, 2'd0, 8'h00, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(0, 0, 2'd0, 8'h00, 0);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; exp_rd[2] = 8'h01; exp_rd[3] = 8'h00;
    do_reset();
    vectors++;
    if (inhibit !== 1'b1 || audio_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outputs inhibit=%b audio=%h want 1/0000", inhibit, audio_out);
    end
    for (int a = 0; a < 4; a++) begin
      cyc(0, 1, 2'(a), 8'h00, 0);
      vectors++;
      if (cpu_dout !== exp_rd[a]) begin
        miscompares++;
        $display("FAIL reset_read addr=%0d got=%h want=%h", a, cpu_dout, exp_rd[a]);
      end
    end
  endtask

  task automatic test_commit();
    cyc(1, 0, 2'd0, 8'hA5, 0);
    cyc(0, 1, 2'd3, 8'h00, 0);
    vectors++;
    if (cpu_dout !== 8'h01 || attack_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL commit_pre status=%h attack=%b want 01/00", cpu_dout, attack_sel);
    end
    tick();
    cyc(0, 1, 2'd3, 8'h00, 0);
    vectors++;
    if ({attack_sel, decay_sel, slf_sel, vco_pitch, noise_pink} !== 8'b01_01_10_0_1
        || cpu_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL commit_post a=%b d=%b s=%b p=%b n=%b status=%h want 01 01 10 0 1 00",
               attack_sel, decay_sel, slf_sel, vco_pitch, noise_pink, cpu_dout);
    end
  endtask

  task automatic test_trigger();
    int high;
    cyc(1, 0, 2'd2, 8'h00, 0);
    tick();
    vectors++;
    if (inhibit !== 1'b0) begin
      miscompares++;
      $display("FAIL trig_clear inhibit=%b want 0", inhibit);
    end
    cyc(1, 0, 2'd2, 8'h02, 0);
    for (int i = 0; i < TH + 2; i++) begin
      tick();
      cyc(0, 1, 2'd3, 8'h00, 0);
      vectors++;
      if (inhibit !== (i < TH) || cpu_dout[1] !== (i < TH)) begin
        miscompares++;
        $display("FAIL trig_hold tick=%0d inhibit=%b active=%b want %b", i, inhibit,
                 cpu_dout[1], i < TH);
      end
    end
    // retrigger at hold tick 2
    high = 0;
    cyc(1, 0, 2'd2, 8'h02, 0);
    tick(); high += int'(inhibit);
    tick(); high += int'(inhibit);
    cyc(1, 0, 2'd2, 8'h02, 0);
    for (int i = 0; i < 10; i++) begin
      tick(); high += int'(inhibit);
    end
    vectors++;
    if (high != 2 + TH) begin
      miscompares++;
      $display("FAIL retrigger high_ticks=%0d want %0d", high, 2 + TH);
    end
  endtask

  task automatic test_inhibit_hold();
    int falls;
    logic prev;
    falls = 0;
    cyc(1, 0, 2'd2, 8'h03, 0);
    prev = inhibit;
    for (int i = 0; i < TH + 4; i++) begin
      tick();
      if (prev && !inhibit) falls++;
      prev = inhibit;
    end
    vectors++;
    if (falls != 0 || inhibit !== 1'b1) begin
      miscompares++;
      $display("FAIL inhibit_hold falls=%0d inhibit=%b want 0/1", falls, inhibit);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 2'd1, 8'h5F, 1);
    cyc(0, 1, 2'd3, 8'h00, 0);
    vectors++;
    if (mixer_ctl !== 3'b000 || cpu_dout !== 8'h01) begin
      miscompares++;
      $display("FAIL coincident_pre mixer=%b status=%h want 000/01", mixer_ctl, cpu_dout);
    end
    tick();
    vectors++;
    if ({mixer_ctl, envsel, vco_sel, vco_ext} !== 7'b111_11_0_1) begin
      miscompares++;
      $display("FAIL coincident_post mixer=%b env=%b vsel=%b vext=%b want 111 11 0 1",
               mixer_ctl, envsel, vco_sel, vco_ext);
    end
  endtask

  task automatic test_audio();
    magnitude = 14'h3FFF;
    tick();
    vectors++;
    if (audio_out !== 16'hFFFC) begin
      miscompares++;
      $display("FAIL audio_vol0 got=%h want=FFFC", audio_out);
    end
    cyc(1, 0, 2'd2, 8'h04, 0);
    tick();
    tick();
    vectors++;
    if (audio_out !== 16'h7FFE) begin
      miscompares++;
      $display("FAIL audio_vol1 got=%h want=7FFE", audio_out);
    end
  endtask

  task automatic test_reset_mid_hold();
    cyc(1, 0, 2'd2, 8'h02, 0);
    tick();
    tick();
    do_reset();
    cyc(0, 1, 2'd3, 8'h00, 0);
    vectors++;
    if (inhibit !== 1'b1 || audio_out !== 16'h0000 || cpu_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold inhibit=%b audio=%h status=%h want 1/0000/00",
               inhibit, audio_out, cpu_dout);
    end
  endtask

  task automatic test_random();
    logic [39:0] got, want;
    for (int i = 0; i < 600; i++) begin
      magnitude = 14'($urandom);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 2'($urandom),
          8'($urandom), $urandom_range(0, 4) == 0);
      got  = {attack_sel, decay_sel, slf_sel, vco_pitch, noise_pink, mixer_ctl, envsel,
              vco_sel, vco_ext, inhibit, audio_out, cpu_dout};
      want = {m_ca[1:0], m_ca[3:2], m_ca[5:4], m_ca[6], m_ca[7], m_cb[2:0], m_cb[4:3],
              m_cb[5], m_cb[6], m_inhibit(), m_audio, m_dout};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL random cycle=%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit();
    test_trigger();
    test_inhibit_hold();
    test_back_to_back();
    test_audio();
    test_random();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
